riscv_regfile: RTL and testbench

Architectural integer register file and lock scoreboard for the RV32 core. It consumes the execute stage's per-port lock and write requests. It returns the full 32x32 register array plus a per-register locked mask, which decode and execute use for operand reads and hazard holds. Per-register lock counters allow multiple in-flight writers to the same register.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/riscv_regfile_lockcnt.sv | 25 ++
 rtl/riscv_regfile.sv | 62 ++++++
 tb/tb_riscv_regfile.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RV32 register file and lock scoreboard.
package riscv_pkg;
  localparam int REGISTER_PORTS = 2;
  localparam int LOCK_CNT_W = 2;
  localparam int CNT_MAX = 2**LOCK_CNT_W - 1;
  localparam int PORT_CNT_W = $clog2(REGISTER_PORTS + 1);
  typedef logic [LOCK_CNT_W-1:0] regfile_lock_cnt_t;
endpackage

// File: rtl/riscv_regfile_lockcnt.sv
// riscv_regfile_lockcnt: saturating outstanding-writer counter for one register.
module riscv_regfile_lockcnt
  import riscv_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PORT_CNT_W-1:0] inc,
  input  logic [PORT_CNT_W-1:0] dec,
  input  logic                  flush,
  output logic                  locked,
  output logic                  ovf,
  output logic                  unf
);
  localparam int NW = LOCK_CNT_W + 2;
  localparam logic signed [NW-1:0] MAX = NW'(CNT_MAX);
  regfile_lock_cnt_t cnt;
  logic signed [NW-1:0] nxt;
  assign nxt = $signed(NW'(cnt)) + $signed(NW'(inc)) - $signed(NW'(dec));
  assign ovf = !flush && nxt > MAX;
  assign unf = !flush && nxt[NW-1];
  assign locked = cnt != '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= flush || unf ? '0 : ovf ? regfile_lock_cnt_t'(CNT_MAX) : regfile_lock_cnt_t'(nxt);
endmodule

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32x32 architectural register file with per-register lock scoreboard.
module riscv_regfile
  import riscv_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [REGISTER_PORTS-1:0]            register_lock_en,
  input  logic [REGISTER_PORTS-1:0][4:0]       register_lock,
  input  logic [REGISTER_PORTS-1:0]            register_write_en,
  input  logic [REGISTER_PORTS-1:0][4:0]       register_write,
  input  logic [REGISTER_PORTS-1:0][31:0]      register_write_data,
  input  logic                                 flush,
  output logic [31:0][31:0]                    register,
  output logic [31:0]                          register_locked,
  output logic                                 lock_overflow,
  output logic                                 write_unlocked
);
  logic [31:1] ovf, unf;
  logic drain;
  assign register[0] = '0;
  assign register_locked[0] = 1'b0;
  for (genvar r = 1; r < 32; r++) begin : g_reg
    logic [PORT_CNT_W-1:0] inc, dec;
    logic [31:0] q, wd;
    // Ports are scanned in ascending order so the highest write port wins the data.
    always_comb begin
      inc = '0;
      dec = '0;
      wd = q;
      for (int p = 0; p < REGISTER_PORTS; p++) begin
        inc = inc + PORT_CNT_W'(register_lock_en[p] && register_lock[p] == 5'(r));
        dec = dec + PORT_CNT_W'(register_write_en[p] && register_write[p] == 5'(r));
        wd = register_write_en[p] && register_write[p] == 5'(r) ? register_write_data[p] : wd;
      end
    end
    always_ff @(posedge clock or negedge reset)
      if (!reset) q <= '0;
      else q <= wd;
    assign register[r] = q;
    riscv_regfile_lockcnt u_cnt (
      .clock  (clock),
      .reset  (reset),
      .inc    (inc),
      .dec    (dec),
      .flush  (flush),
      .locked (register_locked[r]),
      .ovf    (ovf[r]),
      .unf    (unf[r])
    );
  end
  // After a flush, in-flight results may still land on cleared counters; stay quiet until writes stop.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      lock_overflow <= 1'b0;
      write_unlocked <= 1'b0;
      drain <= 1'b0;
    end else begin
      lock_overflow <= |ovf;
      write_unlocked <= |unf && !flush && !drain;
      drain <= flush || (drain && |register_write_en);
    end
endmodule

// File: tb/tb_riscv_regfile.sv
// tb_riscv_regfile: directed table plus randomized traffic against a behavioural scoreboard model.
module tb_riscv_regfile;
  import riscv_pkg::*;
  logic clock = 1'b0, reset = 1'b0;
  logic [REGISTER_PORTS-1:0] lock_en, write_en;
  logic [REGISTER_PORTS-1:0][4:0] lock_idx, write_idx;
  logic [REGISTER_PORTS-1:0][31:0] write_data;
  logic flush;
  logic [31:0][31:0] regs;
  logic [31:0] locked;
  logic ovf, unf;
  int vectors = 0, miscompares = 0;
  logic [31:0] m_reg [32];
  int m_cnt [32];
  bit m_drain, m_ovf, m_unf;

  typedef struct {
    int le, l0, l1, we, w0, w1;
    logic [31:0] d0, d1;
    int fl, ri;
    logic [31:0] rv, lk;
    int ovf, unf;
  } vec_t;
  vec_t tbl[$];

  riscv_regfile dut (
    .clock               (clock),
    .reset               (reset),
    .register_lock_en    (lock_en),
    .register_lock       (lock_idx),
    .register_write_en   (write_en),
    .register_write      (write_idx),
    .register_write_data (write_data),
    .flush               (flush),
    .register            (regs),
    .register_locked     (locked),
    .lock_overflow       (ovf),
    .write_unlocked      (unf)
  );

  always #5 clock = ~clock;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = '0;
      m_cnt[r] = 0;
    end
    m_drain = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step();
    int inc [32];
    int dec [32];
    int n;
    bit o = 0, u = 0;
    for (int r = 0; r < 32; r++) begin
      inc[r] = 0;
      dec[r] = 0;
    end
    for (int p = 0; p < REGISTER_PORTS; p++) begin
      if (lock_en[p]) inc[lock_idx[p]]++;
      if (write_en[p]) begin
        dec[write_idx[p]]++;
        if (write_idx[p] != 0) m_reg[write_idx[p]] = write_data[p];
      end
    end
    for (int r = 1; r < 32; r++) begin
      n = m_cnt[r] + inc[r] - dec[r];
      if (flush) m_cnt[r] = 0;
      else if (n > CNT_MAX) begin m_cnt[r] = CNT_MAX; o = 1; end
      else if (n < 0) begin m_cnt[r] = 0; u = 1; end
      else m_cnt[r] = n;
    end
    m_ovf = o;
    m_unf = u && !flush && !m_drain;
    m_drain = flush || (m_drain && write_en != 0);
  endtask

  task automatic compare_model();
    logic [31:0] mask = '0;
    for (int r = 0; r < 32; r++) begin
      check($sformatf("reg_x%0d", r), regs[r], m_reg[r]);
      mask[r] = m_cnt[r] != 0;
    end
    check("register_locked", locked, mask);
    check("lock_overflow", 32'(ovf), 32'(m_ovf));
    check("write_unlocked", 32'(unf), 32'(m_unf));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    vectors++;
    compare_model();
  endtask

  initial begin
    lock_en = '0; write_en = '0; lock_idx = '0; write_idx = '0; write_data = '0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    compare_model();
    reset = 1'b1;
    //         le l0 l1 we w0 w1 d0            d1          fl ri rv            lk           ovf unf
    tbl.push_back('{0, 0, 0, 1, 5, 0, 32'hDEADBEEF, 0,          0, 5, 32'hDEADBEEF, 0,           0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,            0,          0, 5, 32'hDEADBEEF, 0,           0, 0});
    tbl.push_back('{1, 3, 0, 0, 0, 0, 0,            0,          0, 3, 0,            32'h8,       0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,            0,          0, 3, 0,            32'h8,       0, 0});
    tbl.push_back('{0, 0, 0, 2, 0, 3, 0,            32'h12,     0, 3, 32'h12,       0,           0, 0});
    tbl.push_back('{3, 7, 7, 0, 0, 0, 0,            0,          0, 7, 0,            32'h80,      0, 0});
    tbl.push_back('{0, 0, 0, 3, 7, 7, 32'h1,        32'h2,      0, 7, 32'h2,        0,           0, 0});
    tbl.push_back('{1, 9, 0, 0, 0, 0, 0,            0,          0, 9, 0,            32'h200,     0, 0});
    tbl.push_back('{1, 9, 0, 0, 0, 0, 0,            0,          0, 9, 0,            32'h200,     0, 0});
    tbl.push_back('{1, 9, 0, 0, 0, 0, 0,            0,          0, 9, 0,            32'h200,     0, 0});
    tbl.push_back('{1, 9, 0, 0, 0, 0, 0,            0,          0, 9, 0,            32'h200,     1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,            0,          0, 9, 0,            32'h200,     0, 0});
    tbl.push_back('{0, 0, 0, 1, 9, 0, 32'h9,        0,          0, 9, 32'h9,        32'h200,     0, 0});
    tbl.push_back('{0, 0, 0, 1, 9, 0, 32'h9,        0,          0, 9, 32'h9,        32'h200,     0, 0});
    tbl.push_back('{0, 0, 0, 1, 9, 0, 32'h9,        0,          0, 9, 32'h9,        0,           0, 0});
    tbl.push_back('{3, 4, 4, 0, 0, 0, 0,            0,          0, 4, 0,            32'h10,      0, 0});
    tbl.push_back('{1, 6, 0, 2, 0, 4, 0,            32'h55,     1, 4, 32'h55,       0,           0, 0});
    tbl.push_back('{0, 0, 0, 1, 4, 0, 32'h56,       0,          0, 4, 32'h56,       0,           0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,            0,          0, 4, 32'h56,       0,           0, 0});
    tbl.push_back('{0, 0, 0, 1, 4, 0, 32'h57,       0,          0, 4, 32'h57,       0,           0, 1});
    tbl.push_back('{1, 0, 0, 2, 0, 0, 0,            32'hFFFF,   0, 0, 0,            0,           0, 0});
    tbl.push_back('{3, 1, 1, 1, 1, 0, 32'hA,        0,          0, 1, 32'hA,        32'h2,       0, 0});
    tbl.push_back('{1, 1, 0, 2, 0, 1, 0,            32'hB,      0, 1, 32'hB,        32'h2,       0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 32'hC,        0,          0, 1, 32'hC,        0,           0, 0});
    tbl.push_back('{3, 10, 10, 0, 0, 0, 0,          0,          0, 10, 0,           32'h400,     0, 0});
    tbl.push_back('{1, 10, 0, 0, 0, 0, 0,           0,          0, 10, 0,           32'h400,     0, 0});
    tbl.push_back('{1, 10, 0, 2, 0, 11, 0,          32'h77,     0, 11, 32'h77,      32'h400,     1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,            0,          0, 11, 32'h77,      32'h400,     0, 0});
    foreach (tbl[i]) begin
      lock_en = 2'(tbl[i].le);
      lock_idx[0] = 5'(tbl[i].l0);
      lock_idx[1] = 5'(tbl[i].l1);
      write_en = 2'(tbl[i].we);
      write_idx[0] = 5'(tbl[i].w0);
      write_idx[1] = 5'(tbl[i].w1);
      write_data[0] = tbl[i].d0;
      write_data[1] = tbl[i].d1;
      flush = tbl[i].fl[0];
      tick();
      check($sformatf("row%0d_reg", i), regs[tbl[i].ri[4:0]], tbl[i].rv);
      check($sformatf("row%0d_locked", i), locked, tbl[i].lk);
      check($sformatf("row%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      check($sformatf("row%0d_unf", i), 32'(unf), 32'(tbl[i].unf));
    end
    repeat (400) begin
      for (int p = 0; p < REGISTER_PORTS; p++) begin
        lock_en[p] = $urandom_range(0, 2) == 0;
        write_en[p] = $urandom_range(0, 2) == 0;
        lock_idx[p] = 5'($urandom_range(0, 7));
        write_idx[p] = 5'($urandom_range(0, 7));
        write_data[p] = $urandom;
      end
      flush = $urandom_range(0, 15) == 0;
      tick();
    end
    lock_en = 2'b11; lock_idx[0] = 5'd12; lock_idx[1] = 5'd12;
    write_en = 2'b01; write_idx[0] = 5'd13; write_data[0] = 32'hCAFE0000;
    flush = 1'b0;
    #3 reset = 1'b0;
    #1;
    model_reset();
    vectors++;
    compare_model();
    @(posedge clock);
    #1;
    vectors++;
    compare_model();
    reset = 1'b1;
    lock_en = '0; write_en = '0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
